// File: rtl/debouncer_array.sv
// Multi-channel input conditioner: two-flop synchroniser, stability-window debounce,
// registered rise/fall pulses and long-press / auto-repeat pulses per channel.
module debouncer_array #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 500_000,
  parameter int LONG_TICKS    = 100,
  parameter int REPEAT_TICKS  = 0,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] signal_input,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int HW = $clog2(LONG_TICKS + REPEAT_TICKS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_WRAP = HW'(LONG_TICKS + REPEAT_TICKS);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic          POLARITY  = (ACTIVE_LOW != 0);
  localparam logic          REPEAT_EN = (REPEAT_TICKS > 0);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic          s0;
    logic          s1;
    logic [CW-1:0] cnt;
    logic          lvl_q;
    logic          rise_q;
    logic          fall_q;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_inc;
    logic          lp_q;
    logic          moving;
    logic          done;

    assign moving   = (s0 != s1);
    assign done     = !moving && (cnt == CNT_LAST);
    assign hold_inc = hold + HOLD_ONE;

    // NOTE: every flop here uses non-blocking assignment and an async reset, so all
    // channel state clears the instant rst falls, independent of the clock.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s0  <= 1'b0;
        s1  <= 1'b0;
        cnt <= '0;
      end else begin
        s0 <= signal_input[ch] ^ POLARITY;
        s1 <= s0;
        if (moving || done) cnt <= '0;
        else                cnt <= cnt + CW'(1);
      end
    end

    // Level and edge pulses update only when a full stable window completes.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= done &&  s1 && !lvl_q;
        fall_q <= done && !s1 &&  lvl_q;
        if (done) lvl_q <= s1;
      end
    end

    // Hold counts completed windows while already high; the raising window is excluded
    // because lvl_q is still 0 on that edge.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold <= '0;
        lp_q <= 1'b0;
      end else begin
        lp_q <= 1'b0;
        if (!lvl_q || (done && !s1)) begin
          hold <= '0;
        end else if (done) begin
          if (hold_inc == HOLD_LONG) begin
            lp_q <= 1'b1;
            hold <= hold_inc;
          end else if (REPEAT_EN && hold_inc == HOLD_WRAP) begin
            lp_q <= 1'b1;
            hold <= HOLD_LONG;
          end else if (!REPEAT_EN && hold == HOLD_LONG) begin
            hold <= hold;
          end else begin
            hold <= hold_inc;
          end
        end
      end
    end

    assign level[ch]      = lvl_q;
    assign rise[ch]       = rise_q;
    assign fall[ch]       = fall_q;
    assign long_press[ch] = lp_q;
  end

endmodule

// File: tb/tb_debouncer_array.sv
// Directed bench for debouncer_array (4 ch, window 4, long 3, repeat 2) plus a
// repeat-disabled instance sharing the same inputs.
module tb_debouncer_array;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = 4'h0;

  logic [3:0] level, rise, fall, long_press;
  logic [3:0] level_nr, rise_nr, fall_nr, lp_nr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] lvl_acc, rise_acc, fall_acc, lp_acc;
  int         lp_cnt, lp_nr_cnt;

  always #5 clk = ~clk;

  debouncer_array #(
    .CHANNELS(4), .STABLE_CYCLES(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .signal_input(din),
    .level(level), .rise(rise), .fall(fall), .long_press(long_press)
  );

  debouncer_array #(
    .CHANNELS(4), .STABLE_CYCLES(4), .LONG_TICKS(3), .REPEAT_TICKS(0), .ACTIVE_LOW(0)
  ) dut_nr (
    .clk(clk), .rst(rst), .signal_input(din),
    .level(level_nr), .rise(rise_nr), .fall(fall_nr), .long_press(lp_nr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_acc();
    lvl_acc   = '0;
    rise_acc  = '0;
    fall_acc  = '0;
    lp_acc    = '0;
    lp_cnt    = 0;
    lp_nr_cnt = 0;
  endtask

  // Advance one clock and sample 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    lvl_acc  |= level;
    rise_acc |= rise;
    fall_acc |= fall;
    lp_acc   |= long_press;
    if (long_press[3]) lp_cnt++;
    if (lp_nr[3])      lp_nr_cnt++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    clear_acc();

    // Reset with all inputs high, then qualify all channels together.
    din = 4'hF;
    ticks(3);
    check("rst_outputs", {level, rise, fall, long_press}, 16'h0);
    rst = 1'b1;
    #1;
    check("release_outputs", {level, rise, fall, long_press}, 16'h0);
    clear_acc();
    ticks(5);
    check("all_level_e4", level, 4'h0);
    tick();
    check("all_level_e5", level, 4'hF);
    check("all_rise_e5", rise, 4'hF);
    tick();
    check("all_rise_e6", rise, 4'h0);
    check("all_level_e6", level, 4'hF);
    din = 4'h0;
    ticks(5);
    check("all_fall_e4", fall, 4'h0);
    tick();
    check("all_fall_e5", fall, 4'hF);
    check("all_level_low", level, 4'h0);
    tick();
    check("all_fall_e6", fall, 4'h0);
    check("all_no_lp", lp_acc, 4'h0);

    // ch0 clean step.
    clear_acc();
    din = 4'h1;
    ticks(5);
    check("ch0_level_e4", level, 4'h0);
    tick();
    check("ch0_level_e5", level, 4'h1);
    check("ch0_rise_e5", rise, 4'h1);
    tick();
    check("ch0_rise_e6", rise, 4'h0);
    check("ch0_rise_only", rise_acc, 4'h1);
    din = 4'h0;
    ticks(8);
    check("ch0_release_level", level, 4'h0);
    check("ch0_release_fall", fall_acc, 4'h1);

    // ch1 bounce, toggling every 2 cycles, finally settling high.
    clear_acc();
    for (int i = 0; i < 10; i++) begin
      din[1] = (i % 2 == 0);
      ticks(2);
    end
    din[1] = 1'b1;
    ticks(5);
    check("ch1_bounce_level", lvl_acc, 4'h0);
    check("ch1_bounce_rise", rise_acc, 4'h0);
    tick();
    check("ch1_settle_level", level, 4'h2);
    check("ch1_settle_rise", rise, 4'h2);
    tick();
    check("ch1_rise_gone", rise, 4'h0);
    check("ch1_no_fall", fall_acc, 4'h0);
    din = 4'h0;
    ticks(8);
    check("ch1_release_level", level, 4'h0);

    // ch2 three-cycle glitch must be rejected.
    clear_acc();
    din[2] = 1'b1;
    ticks(3);
    din[2] = 1'b0;
    ticks(10);
    check("ch2_glitch_level", lvl_acc, 4'h0);
    check("ch2_glitch_rise", rise_acc, 4'h0);
    check("ch2_glitch_fall", fall_acc, 4'h0);

    // ch3 long press with auto-repeat, then release mid-repeat.
    clear_acc();
    din = 4'h8;
    ticks(6);
    check("ch3_rise", rise, 4'h8);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 11) check("ch3_lp_r11", long_press, 4'h0);
      if (k == 12) check("ch3_lp_r12", long_press, 4'h8);
      if (k == 12) check("ch3_nr_lp_r12", lp_nr, 4'h8);
      if (k == 13) check("ch3_lp_r13", long_press, 4'h0);
      if (k == 20) check("ch3_lp_r20", long_press, 4'h8);
      if (k == 20) check("ch3_nr_lp_r20", lp_nr, 4'h0);
      if (k == 21) check("ch3_lp_r21", long_press, 4'h0);
      if (k == 28) check("ch3_lp_r28", long_press, 4'h8);
    end
    check("ch3_lp_count", lp_cnt, 3);
    check("ch3_nr_lp_count", lp_nr_cnt, 1);
    din = 4'h0;
    ticks(5);
    check("ch3_fall_early", fall, 4'h0);
    tick();
    check("ch3_fall", fall, 4'h8);
    check("ch3_fall_no_lp", long_press, 4'h0);
    ticks(10);
    check("ch3_lp_after_rel", lp_cnt, 3);
    check("ch3_nr_after_rel", lp_nr_cnt, 1);
    check("ch3_lp_only_ch3", lp_acc, 4'h8);

    // Reset in the middle of a hold; input stays high across it.
    din = 4'h8;
    ticks(6);
    check("rst_mid_rise", rise, 4'h8);
    ticks(8);
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", {level, rise, fall, long_press}, 16'h0);
    check("rst_mid_nr_outputs", {level_nr, rise_nr, fall_nr, lp_nr}, 16'h0);
    ticks(2);
    check("rst_mid_hold_level", level, 4'h0);
    rst = 1'b1;
    clear_acc();
    ticks(5);
    check("requal_level_e4", level, 4'h0);
    check("requal_no_pulse", {rise_acc, fall_acc, lp_acc}, 12'h0);
    tick();
    check("requal_rise", rise, 4'h8);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 11) check("requal_lp_none_yet", lp_cnt, 0);
      if (k == 12) check("requal_lp_r12", long_press, 4'h8);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
